// File: rtl/memory_cycle.sv
// MEM stage: drives the data-memory port, extends load data and feeds MEM/WB.
// Optional misaligned-access trap enabled by MEM_MISALIGN_TRAP_EN.
module memory_cycle #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] InstrM,
  input  logic [4:0]  RdM,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic [4:0]  RdW,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic        StallM,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic        misalign,
`endif
  output logic        bus_err
);

  typedef enum logic {IDLE, BUSY} state_t;
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t         state, stateNext;
  logic [CW-1:0]  cnt;
  logic [31:0]    addrQ, wdataQ;
  logic           weQ;
  logic [3:0]     beQ;
  logic [2:0]     f3Q;
  logic [1:0]     offQ;

  logic [2:0]  f3, f3Eff;
  logic [1:0]  off, offEff;
  logic        memOp, misTrap, timeout, bubble;
  logic [3:0]  beCur;
  logic [31:0] wdataCur, loadData;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  logic unusedInstr;
  assign unusedInstr = ^{InstrM[31:15], InstrM[11:0]};

  assign f3    = InstrM[14:12];
  assign off   = ALUResultM[1:0];
  assign memOp = MemWriteM | (ResultSrcM == 2'b01);

  // Store lane steering; undefined store widths behave as SW.
  always_comb begin
    beCur    = 4'b1111;
    wdataCur = WriteDataM;
    case (f3)
      3'b000: begin
        beCur    = 4'b0001 << off;
        wdataCur = {4{WriteDataM[7:0]}};
      end
      3'b001: begin
        beCur    = off[1] ? 4'b1100 : 4'b0011;
        wdataCur = {2{WriteDataM[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic misAddr;
  always_comb begin
    misAddr = (off != 2'b00);
    if (MemWriteM) begin
      if (f3 == 3'b000)      misAddr = 1'b0;
      else if (f3 == 3'b001) misAddr = off[0];
    end else begin
      if (f3 == 3'b000 || f3 == 3'b100)      misAddr = 1'b0;
      else if (f3 == 3'b001 || f3 == 3'b101) misAddr = off[0];
    end
  end
  assign misTrap = !rst && (state == IDLE) && memOp && misAddr;
`else
  assign misTrap = 1'b0;
`endif

  // Load extraction follows the access actually on the bus.
  assign f3Eff  = (state == BUSY) ? f3Q  : f3;
  assign offEff = (state == BUSY) ? offQ : off;

  always_comb begin
    case (offEff)
      2'd0:    byteSel = dmem_rdata[7:0];
      2'd1:    byteSel = dmem_rdata[15:8];
      2'd2:    byteSel = dmem_rdata[23:16];
      default: byteSel = dmem_rdata[31:24];
    endcase
    halfSel = offEff[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (f3Eff)
      3'b000:  loadData = {{24{byteSel[7]}}, byteSel};
      3'b001:  loadData = {{16{halfSel[15]}}, halfSel};
      3'b100:  loadData = {24'b0, byteSel};
      3'b101:  loadData = {16'b0, halfSel};
      default: loadData = dmem_rdata;
    endcase
  end

  always_comb begin
    stateNext  = state;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = {ALUResultM[31:2], 2'b00};
    dmem_be    = beCur;
    dmem_wdata = wdataCur;
    StallM     = 1'b0;
    timeout    = 1'b0;
    if (state == BUSY) begin
      dmem_addr  = addrQ;
      dmem_be    = beQ;
      dmem_wdata = wdataQ;
    end
    if (!rst) begin
      case (state)
        IDLE: begin
          if (memOp && !misTrap) begin
            dmem_req = 1'b1;
            dmem_we  = MemWriteM;
            if (!dmem_ready) begin
              StallM    = 1'b1;
              stateNext = BUSY;
            end
          end
        end
        BUSY: begin
          dmem_req = 1'b1;
          dmem_we  = weQ;
          if (dmem_ready) begin
            stateNext = IDLE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            timeout   = 1'b1;
            stateNext = IDLE;
          end else begin
            StallM = 1'b1;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  assign bubble = timeout | misTrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      addrQ      <= '0;
      wdataQ     <= '0;
      weQ        <= 1'b0;
      beQ        <= '0;
      f3Q        <= '0;
      offQ       <= '0;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCPlus4W   <= '0;
      RdW        <= '0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= '0;
      bus_err    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign   <= 1'b0;
`endif
    end else begin
      state   <= stateNext;
      bus_err <= timeout;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign <= misTrap;
`endif
      if (state == IDLE && stateNext == BUSY) begin
        cnt    <= '0;
        addrQ  <= {ALUResultM[31:2], 2'b00};
        wdataQ <= wdataCur;
        weQ    <= MemWriteM;
        beQ    <= beCur;
        f3Q    <= f3;
        offQ   <= off;
      end else if (state == BUSY) begin
        cnt <= cnt + 1'b1;
      end
      if (!StallM) begin
        ALUResultW <= ALUResultM;
        ReadDataW  <= loadData;
        PCPlus4W   <= PCPlus4M;
        ResultSrcW <= ResultSrcM;
        RdW        <= bubble ? 5'd0 : RdM;
        RegWriteW  <= RegWriteM & ~bubble;
      end else begin
        RdW       <= '0;
        RegWriteW <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for memory_cycle: stores, loads, wait states, timeout, reset, misalignment.
module tb_memory_cycle;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M, InstrM;
  logic [4:0]  RdM;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
  logic [4:0]  RdW;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic        StallM, bus_err;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int errors = 0;
  int checks = 0;
  int storeCnt = 0;

  memory_cycle dut (
    .clk(clk), .rst(rst),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .InstrM(InstrM), .RdM(RdM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
    .RdW(RdW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .StallM(StallM),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign(misalign),
`endif
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && dmem_req && dmem_ready && dmem_we) storeCnt++;

  task automatic setOp(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                       input logic we, input logic [1:0] rs, input logic rw, input logic [4:0] rd);
    InstrM     = 32'(f3) << 12;
    ALUResultM = addr;
    WriteDataM = wd;
    MemWriteM  = we;
    ResultSrcM = rs;
    RegWriteM  = rw;
    RdM        = rd;
  endtask

  task automatic setIdle();
    setOp(3'b000, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 5'd0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    setOp(3'b010, 32'h104, 32'hDEADBEEF, 1'b1, 2'b00, 1'b1, 5'd3);
    dmem_ready = 1'b1;
    #1;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", dmem_req); end
    @(posedge clk); #1;
    checks++; if ({ALUResultW, ReadDataW, PCPlus4W, RdW, RegWriteW, ResultSrcW, bus_err} !== '0)
      begin errors++; $display("FAIL rst_outs: alu %h rd %h pc %h rdw %0d rw %b rs %b be %b want all 0",
        ALUResultW, ReadDataW, PCPlus4W, RdW, RegWriteW, ResultSrcW, bus_err); end
    @(negedge clk);
    rst = 1'b0;
    setIdle();
  endtask

  task automatic test_alu_pass();
    @(negedge clk);
    setOp(3'b000, 32'h12345678, 32'h0, 1'b0, 2'b10, 1'b1, 5'd7);
    PCPlus4M = 32'h44;
    #1;
    checks++; if ({dmem_req, StallM} !== 2'b00) begin errors++; $display("FAIL alu_noreq: got req %b stall %b want 0 0", dmem_req, StallM); end
    @(posedge clk); #1;
    checks++; if ({ALUResultW, PCPlus4W, RdW, RegWriteW, ResultSrcW} !== {32'h12345678, 32'h44, 5'd7, 1'b1, 2'b10})
      begin errors++; $display("FAIL alu_pass: got alu %h pc %h rd %0d rw %b rs %b want 12345678 44 7 1 10",
        ALUResultW, PCPlus4W, RdW, RegWriteW, ResultSrcW); end
  endtask

  task automatic test_sw();
    @(negedge clk);
    storeCnt = 0;
    setOp(3'b010, 32'h104, 32'hDEADBEEF, 1'b1, 2'b00, 1'b0, 5'd0);
    dmem_ready = 1'b1;
    #1;
    checks++; if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, StallM} !== {2'b11, 32'h104, 4'b1111, 32'hDEADBEEF, 1'b0})
      begin errors++; $display("FAIL sw_port: got req %b we %b addr %h be %b wd %h stall %b want 1 1 104 1111 deadbeef 0",
        dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, StallM); end
    @(posedge clk); #1;
    checks++; if (RegWriteW !== 1'b0) begin errors++; $display("FAIL sw_rw: got %b want 0", RegWriteW); end
    @(negedge clk);
    setOp(3'b000, 32'h101, 32'h00000055, 1'b1, 2'b00, 1'b0, 5'd0);
    #1;
    checks++; if ({dmem_addr, dmem_be, dmem_wdata} !== {32'h100, 4'b0010, 32'h55555555})
      begin errors++; $display("FAIL sb_port: got addr %h be %b wd %h want 100 0010 55555555", dmem_addr, dmem_be, dmem_wdata); end
    @(posedge clk);
    @(negedge clk);
    setIdle();
    #1;
    checks++; if (storeCnt !== 2) begin errors++; $display("FAIL sw_count: got %0d want 2", storeCnt); end
  endtask

  task automatic test_sh_wait();
    @(negedge clk);
    storeCnt = 0;
    setOp(3'b001, 32'h102, 32'h1234ABCD, 1'b1, 2'b00, 1'b0, 5'd0);
    dmem_ready = 1'b0;
    #1;
    checks++; if ({dmem_be, dmem_wdata, StallM} !== {4'b1100, 32'hABCDABCD, 1'b1})
      begin errors++; $display("FAIL sh_port: got be %b wd %h stall %b want 1100 abcdabcd 1", dmem_be, dmem_wdata, StallM); end
    @(posedge clk);
    @(negedge clk);
    WriteDataM = 32'h0;
    ALUResultM = 32'h0;
    #1;
    checks++; if ({dmem_req, dmem_addr, dmem_be, dmem_wdata} !== {1'b1, 32'h100, 4'b1100, 32'hABCDABCD})
      begin errors++; $display("FAIL sh_hold: got req %b addr %h be %b wd %h want 1 100 1100 abcdabcd",
        dmem_req, dmem_addr, dmem_be, dmem_wdata); end
    @(posedge clk);
    @(negedge clk);
    dmem_ready = 1'b1;
    #1;
    checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL sh_release: got %b want 0", StallM); end
    @(posedge clk);
    @(negedge clk);
    setIdle();
    dmem_ready = 1'b0;
    @(posedge clk); #1;
    checks++; if (storeCnt !== 1) begin errors++; $display("FAIL sh_once: got %0d want 1", storeCnt); end
  endtask

  task automatic test_lb_wait();
    @(negedge clk);
    setOp(3'b000, 32'h203, 32'h0, 1'b0, 2'b01, 1'b1, 5'd5);
    dmem_ready = 1'b0;
    dmem_rdata = 32'h80000000;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({StallM, dmem_req, dmem_addr} !== {2'b11, 32'h200})
        begin errors++; $display("FAIL lb_stall%0d: got stall %b req %b addr %h want 1 1 200", i, StallM, dmem_req, dmem_addr); end
      @(posedge clk); #1;
      checks++; if (RegWriteW !== 1'b0) begin errors++; $display("FAIL lb_bubble%0d: got %b want 0", i, RegWriteW); end
      @(negedge clk);
    end
    dmem_ready = 1'b1;
    #1;
    checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL lb_release: got %b want 0", StallM); end
    @(posedge clk); #1;
    checks++; if ({ReadDataW, RegWriteW, RdW} !== {32'hFFFFFF80, 1'b1, 5'd5})
      begin errors++; $display("FAIL lb_data: got %h rw %b rd %0d want ffffff80 1 5", ReadDataW, RegWriteW, RdW); end
    @(negedge clk);
    setIdle();
  endtask

  task automatic test_loads();
    logic [2:0]  f3s [8];
    logic [31:0] ads [8], rds [8], exs [8];
    f3s = '{3'b001, 3'b101, 3'b001, 3'b100, 3'b000, 3'b010, 3'b011, 3'b000};
    ads = '{32'h102, 32'h102, 32'h100, 32'h201, 32'h200, 32'h200, 32'h200, 32'h202};
    rds = '{32'h80017FFF, 32'h80017FFF, 32'h80017FFF, 32'h00009A00,
            32'h0000007F, 32'hCAFEF00D, 32'h13572468, 32'h00F00000};
    exs = '{32'hFFFF8001, 32'h00008001, 32'h00007FFF, 32'h0000009A,
            32'h0000007F, 32'hCAFEF00D, 32'h13572468, 32'hFFFFFFF0};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      setOp(f3s[i], ads[i], 32'h0, 1'b0, 2'b01, 1'b1, 5'd3);
      dmem_ready = 1'b1;
      dmem_rdata = rds[i];
      @(posedge clk); #1;
      checks++; if (ReadDataW !== exs[i])
        begin errors++; $display("FAIL load%0d: got %h want %h", i, ReadDataW, exs[i]); end
    end
    @(negedge clk);
    setIdle();
  endtask

  task automatic test_timeout();
    int stalls = 0, reqLow = 0;
    bit done = 0;
    @(negedge clk);
    setOp(3'b101, 32'h100, 32'h0, 1'b0, 2'b01, 1'b1, 5'd9);
    dmem_ready = 1'b0;
    for (int i = 0; i < 600; i++) begin
      #1;
      if (!dmem_req) reqLow++;
      if (StallM) stalls++; else done = 1;
      @(posedge clk); #1;
      if (done) break;
      @(negedge clk);
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL to_bound: StallM never released"); end
    checks++; if (stalls !== 255) begin errors++; $display("FAIL to_stalls: got %0d want 255", stalls); end
    checks++; if (reqLow !== 0) begin errors++; $display("FAIL to_req: req low %0d cycles want 0", reqLow); end
    checks++; if ({bus_err, RegWriteW} !== 2'b10) begin errors++; $display("FAIL to_err: got err %b rw %b want 1 0", bus_err, RegWriteW); end
    @(negedge clk);
    setIdle();
    #1;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL to_drop: got %b want 0", dmem_req); end
    @(posedge clk); #1;
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL to_pulse: got %b want 0", bus_err); end
  endtask

  task automatic test_reset_busy();
    @(negedge clk);
    setOp(3'b010, 32'h100, 32'h0, 1'b0, 2'b01, 1'b1, 5'd4);
    dmem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rb_req: got %b want 0", dmem_req); end
    @(posedge clk); #1;
    checks++; if ({ALUResultW, RdW, RegWriteW, bus_err} !== '0)
      begin errors++; $display("FAIL rb_outs: got alu %h rd %0d rw %b err %b want 0", ALUResultW, RdW, RegWriteW, bus_err); end
    @(negedge clk);
    rst = 1'b0;
    ALUResultM = 32'h300;
    #1;
    checks++; if ({dmem_req, dmem_addr} !== {1'b1, 32'h300})
      begin errors++; $display("FAIL rb_idle: got req %b addr %h want 1 300", dmem_req, dmem_addr); end
    dmem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    setIdle();
  endtask

  task automatic test_misalign();
    @(negedge clk);
    setOp(3'b010, 32'h101, 32'h0, 1'b0, 2'b01, 1'b1, 5'd6);
    dmem_ready = 1'b1;
    dmem_rdata = 32'h11223344;
    #1;
`ifdef MEM_MISALIGN_TRAP_EN
    checks++; if ({dmem_req, StallM} !== 2'b00) begin errors++; $display("FAIL mis_req: got req %b stall %b want 0 0", dmem_req, StallM); end
    @(posedge clk); #1;
    checks++; if ({misalign, RegWriteW} !== 2'b10) begin errors++; $display("FAIL mis_trap: got mis %b rw %b want 1 0", misalign, RegWriteW); end
    @(negedge clk);
    setIdle();
    @(posedge clk); #1;
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_pulse: got %b want 0", misalign); end
`else
    checks++; if ({dmem_req, dmem_addr, dmem_be} !== {1'b1, 32'h100, 4'b1111})
      begin errors++; $display("FAIL mis_align: got req %b addr %h be %b want 1 100 1111", dmem_req, dmem_addr, dmem_be); end
    @(posedge clk); #1;
    checks++; if ({RegWriteW, ReadDataW} !== {1'b1, 32'h11223344})
      begin errors++; $display("FAIL mis_load: got rw %b data %h want 1 11223344", RegWriteW, ReadDataW); end
    @(negedge clk);
    setIdle();
`endif
  endtask

  initial begin
    rst = 1'b1;
    setIdle();
    PCPlus4M   = 32'h0;
    dmem_rdata = 32'h0;
    dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_alu_pass();
    test_sw();
    test_sh_wait();
    test_lb_wait();
    test_loads();
    test_timeout();
    test_reset_busy();
    test_misalign();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/memory_cycle.md
MEMORY_CYCLE -- requirements
Module: memory_cycle

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-002 SHALL accept the EX/MEM bundle as inputs: ALUResultM 32 (address or ALU result); WriteDataM 32 (store data); PCPlus4M 32; InstrM 32 (funct3 = InstrM[14:12]); RdM 5; RegWriteM 1; MemWriteM 1; ResultSrcM 2 (00 ALU, 01 load, 10 PC+4).
REQ-003 SHALL drive data-memory port outputs: dmem_req 1; dmem_we 1; dmem_addr 32 (word-aligned); dmem_wdata 32; dmem_be 4 (byte enables).
REQ-004 SHALL accept data-memory port inputs: dmem_rdata 32 and dmem_ready 1.
REQ-005 SHALL drive MEM/WB outputs: ALUResultW 32; ReadDataW 32 (extended load data); PCPlus4W 32; RdW 5; RegWriteW 1; ResultSrcW 2.
REQ-006 SHALL drive StallM out 1 (freeze IF/ID/EX and hold EX/MEM) and bus_err out 1 (one-cycle timeout pulse).
REQ-007 SHALL have parameter TIMEOUT, default 255, giving the maximum number of BUSY cycles.

Function
REQ-008 A memory op SHALL be MemWriteM=1 (store) or ResultSrcM=01 (load); all other inputs pass through to MEM/WB with no memory access.
REQ-009 FSM states SHALL be IDLE and BUSY.
REQ-010 In IDLE with a memory op, dmem_req SHALL assert combinationally that cycle with dmem_addr = {ALUResultM[31:2],2'b00}, dmem_we = MemWriteM, and be/wdata as in REQ-013.
REQ-011 If dmem_ready=1 in the same cycle, the op SHALL retire with zero stall; otherwise the FSM SHALL go to BUSY and latch addr/we/be/wdata.
REQ-012 In BUSY, dmem_req SHALL stay 1 and addr/we/be/wdata SHALL stay stable from the latched copies until a cycle with dmem_ready=1, after which the FSM returns to IDLE.
REQ-013 Stores SHALL use: SB be=1<<addr[1:0] with the byte replicated x4; SH be=addr[1]?1100:0011 with the half replicated x2; SW be=1111.
REQ-014 Loads SHALL select a byte/half from dmem_rdata by addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through; an undefined funct3 SHALL be treated as LW.
REQ-015 StallM SHALL equal (memory op present) AND NOT (dmem_ready AND retiring this cycle).
REQ-016 The MEM/WB register SHALL update on every non-stalled cycle; in stalled cycles it SHALL load a bubble (RegWriteW=0, RdW=0, other fields hold).
REQ-017 A BUSY cycle counter SHALL clear on entry to BUSY; when it reaches TIMEOUT without ready, the block SHALL pulse bus_err, drop dmem_req, return to IDLE, and retire the op as a bubble (RegWriteW=0).
REQ-018 Latency SHALL be 1 cycle from EX/MEM to MEM/WB plus N wait cycles, where N is the number of cycles with dmem_ready low.
REQ-019 A store SHALL never issue twice: a ready accepted in BUSY retires the op before the next op is sampled.

Reset
REQ-020 With rst=1 at a clock edge, the block SHALL enter IDLE and clear the counter; all MEM/WB outputs SHALL be 0 and bus_err 0.
REQ-021 While rst=1, dmem_req SHALL be 0 regardless of inputs; a reset in BUSY SHALL abandon the access.

Configuration
REQ-022 With macro MEM_MISALIGN_TRAP_EN defined, a misaligned LH/LHU/SH (addr[0]=1) or LW/SW (addr[1:0]!=0) SHALL suppress dmem_req, retire as a bubble, and pulse output misalign 1 for one cycle.
REQ-023 Without MEM_MISALIGN_TRAP_EN, the misalign port SHALL not exist and the offending low address bits SHALL be ignored (access forced to the natural boundary).

Verification
REQ-024 SW with ALUResultM=0x104, WriteDataM=0xDEADBEEF, dmem_ready=1 -> req/we=1, addr=0x104, be=1111, StallM=0, RegWriteW=0 next cycle.
REQ-025 LB with addr=0x203, rdata=0x80000000, ready low 3 cycles -> StallM=1 for 3 cycles, ReadDataW=0xFFFFFF80 with RegWriteW=1 on the edge after ready.
REQ-026 SH with addr=0x102, data=0x1234ABCD -> be=1100, wdata=0xABCDABCD; with ready low for 2 cycles, exactly one accepted store.
REQ-027 LHU with addr=0x100, ready never asserted -> bus_err pulse after 255 BUSY cycles, req drops, RegWriteW=0, StallM releases.
REQ-028 rst asserted during BUSY -> dmem_req=0 and all outputs 0 on the next cycle, FSM in IDLE.
REQ-029 With MEM_MISALIGN_TRAP_EN, LW with addr=0x101 -> no req, misalign pulse, bubble; without it -> req with addr=0x100, be=1111.
